// File: rtl/input_debouncer.sv
// W-channel switch/button debouncer: per-channel synchroniser followed by a
// tick-sampled stability counter, with registered level and rise/fall strobes.
module input_debouncer #(
   parameter int unsigned W           = 1,
   parameter int unsigned STABLE      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic [W-1:0] raw,
   output logic [W-1:0] state,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   localparam int unsigned   CW       = $clog2(STABLE + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } fsm_t;

   genvar k;
   generate
      for (k = 0; k < W; k++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_r;
         logic                   s_s;
         fsm_t                   fsm_r;
         fsm_t                   fsm_nx_s;
         logic [CW-1:0]          cnt_r;
         logic [CW-1:0]          cnt_nx_s;
         logic                   state_r;
         logic                   state_nx_s;
         logic                   rise_r;
         logic                   rise_nx_s;
         logic                   fall_r;
         logic                   fall_nx_s;

         // synchroniser shift chain, clocked every cycle regardless of tick
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_r <= {SYNC_STAGES{RST_VAL}};
            end else begin
               sync_r <= {sync_r[SYNC_STAGES-2:0], raw[k]};
            end
         end

         assign s_s = sync_r[SYNC_STAGES-1];

         // next-state logic; only a tick may advance the counter or the level
         always_comb begin
            fsm_nx_s   = fsm_r;
            cnt_nx_s   = cnt_r;
            state_nx_s = state_r;
            rise_nx_s  = 1'b0;
            fall_nx_s  = 1'b0;
            if (tick) begin
               case (fsm_r)
                  IDLE: begin
                     if (s_s != state_r) begin
                        if (cnt_r == CNT_LAST) begin
                           // STABLE=1: accept on the first disagreeing tick
                           state_nx_s = s_s;
                           rise_nx_s  = s_s;
                           fall_nx_s  = ~s_s;
                           cnt_nx_s   = CNT_ZERO;
                           fsm_nx_s   = IDLE;
                        end else begin
                           cnt_nx_s = cnt_r + CNT_ONE;
                           fsm_nx_s = PEND;
                        end
                     end else begin
                        cnt_nx_s = CNT_ZERO;
                        fsm_nx_s = IDLE;
                     end
                  end
                  PEND: begin
                     if (s_s == state_r) begin
                        cnt_nx_s = CNT_ZERO;
                        fsm_nx_s = IDLE;
                     end else if (cnt_r == CNT_LAST) begin
                        state_nx_s = s_s;
                        rise_nx_s  = s_s;
                        fall_nx_s  = ~s_s;
                        cnt_nx_s   = CNT_ZERO;
                        fsm_nx_s   = IDLE;
                     end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                        fsm_nx_s = PEND;
                     end
                  end
                  default: begin
                     cnt_nx_s = CNT_ZERO;
                     fsm_nx_s = IDLE;
                  end
               endcase
            end else begin
               rise_nx_s = 1'b0;
               fall_nx_s = 1'b0;
            end
         end

         // channel FSM, counter, debounced level and strobe registers
         always_ff @(posedge clk) begin
            if (rst) begin
               fsm_r   <= IDLE;
               cnt_r   <= CNT_ZERO;
               state_r <= RST_VAL;
               rise_r  <= 1'b0;
               fall_r  <= 1'b0;
            end else begin
               fsm_r   <= fsm_nx_s;
               cnt_r   <= cnt_nx_s;
               state_r <= state_nx_s;
               rise_r  <= rise_nx_s;
               fall_r  <= fall_nx_s;
            end
         end

         assign state[k] = state_r;
         assign rise[k]  = rise_r;
         assign fall[k]  = fall_r;
      end
   endgenerate

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: a 2-channel STABLE=4 instance with a 1-in-5 tick, and a
// 1-channel STABLE=1 instance with tick tied high.
module tb_input_debouncer;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [1:0] raw;
   logic [1:0] state_a;
   logic [1:0] rise_a;
   logic [1:0] fall_a;
   logic       tick_b = 1'b1;
   logic [0:0] raw_b;
   logic [0:0] state_b;
   logic [0:0] rise_b;
   logic [0:0] fall_b;

   int n_checks = 0;
   int n_pass   = 0;

   input_debouncer #(.W(2), .STABLE(4), .SYNC_STAGES(2), .RST_VAL(1'b0)) dut_a (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .raw   (raw),
      .state (state_a),
      .rise  (rise_a),
      .fall  (fall_a)
   );

   input_debouncer #(.W(1), .STABLE(1), .SYNC_STAGES(2), .RST_VAL(1'b0)) dut_b (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick_b),
      .raw   (raw_b),
      .state (state_b),
      .rise  (rise_b),
      .fall  (fall_b)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // one clock cycle with the given tick value; outputs readable 1 time unit after the edge
   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic tick5();
      repeat (4) cyc(1'b0);
      cyc(1'b1);
   endtask

   task automatic chk_a(input string tag, input logic [1:0] st, input logic [1:0] ri, input logic [1:0] fa);
      check_val({tag, "_state"}, {6'd0, state_a}, {6'd0, st});
      check_val({tag, "_rise"},  {6'd0, rise_a},  {6'd0, ri});
      check_val({tag, "_fall"},  {6'd0, fall_a},  {6'd0, fa});
   endtask

   initial begin
      logic [15:0] pat;
      logic        exp_s;
      logic        exp_p;

      rst   = 1'b1;
      tick  = 1'b0;
      raw   = 2'b11;
      raw_b = 1'b0;

      // reset holds everything at zero even with raw high and ticks arriving
      for (int i = 0; i < 10; i++) begin
         cyc((i % 5) == 4);
         chk_a("reset", 2'b00, 2'b00, 2'b00);
      end
      rst = 1'b0;
      raw = 2'b00;
      cyc(1'b0);
      chk_a("post_reset", 2'b00, 2'b00, 2'b00);
      repeat (3) cyc(1'b0);

      // glitch on channel 0 lasting 3 ticks is rejected
      raw = 2'b01;
      cyc(1'b0);
      cyc(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick5();
         chk_a("glitch_hold", 2'b00, 2'b00, 2'b00);
      end
      raw = 2'b00;
      cyc(1'b0);
      cyc(1'b0);
      cyc(1'b1);
      chk_a("glitch_end", 2'b00, 2'b00, 2'b00);

      // clean press on channel 0 needs 4 full fresh ticks
      raw = 2'b01;
      cyc(1'b0);
      cyc(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick5();
         chk_a("press0_wait", 2'b00, 2'b00, 2'b00);
      end
      tick5();
      chk_a("press0_edge", 2'b01, 2'b01, 2'b00);
      cyc(1'b0);
      chk_a("press0_after", 2'b01, 2'b00, 2'b00);

      // channel 1 press; the tick on the edge where s changes does not count
      raw = 2'b11;
      cyc(1'b0);
      cyc(1'b1);
      chk_a("press1_e", 2'b01, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++) begin
         tick5();
         chk_a("press1_wait", 2'b01, 2'b00, 2'b00);
      end
      tick5();
      chk_a("press1_edge", 2'b11, 2'b10, 2'b00);
      cyc(1'b0);
      chk_a("press1_after", 2'b11, 2'b00, 2'b00);

      // simultaneous release on both channels
      raw = 2'b00;
      cyc(1'b0);
      cyc(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick5();
         chk_a("release_wait", 2'b11, 2'b00, 2'b00);
      end
      tick5();
      chk_a("release_edge", 2'b00, 2'b00, 2'b11);
      cyc(1'b0);
      chk_a("release_after", 2'b00, 2'b00, 2'b00);

      // reset in the middle of a count discards it
      raw = 2'b10;
      cyc(1'b0);
      cyc(1'b0);
      tick5();
      tick5();
      chk_a("midrst_pre", 2'b00, 2'b00, 2'b00);
      rst = 1'b1;
      cyc(1'b1);
      rst = 1'b0;
      chk_a("midrst_rst", 2'b00, 2'b00, 2'b00);
      cyc(1'b0);
      chk_a("midrst_next", 2'b00, 2'b00, 2'b00);
      cyc(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick5();
         chk_a("midrst_wait", 2'b00, 2'b00, 2'b00);
      end
      tick5();
      chk_a("midrst_edge", 2'b10, 2'b10, 2'b00);

      // STABLE=1 with tick always high: state is raw delayed by three edges
      pat = 16'b0000_0000_1101_0101;
      for (int j = 0; j < 16; j++) begin
         raw_b = pat[j];
         cyc(1'b0);
         exp_s = (j >= 2) ? pat[j-2] : 1'b0;
         exp_p = (j >= 3) ? pat[j-3] : 1'b0;
         check_val("s1_state", {7'd0, state_b}, {7'd0, exp_s});
         check_val("s1_rise",  {7'd0, rise_b},  {7'd0, (exp_s & ~exp_p)});
         check_val("s1_fall",  {7'd0, fall_b},  {7'd0, (~exp_s & exp_p)});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
